// File: rtl/muldiv_pkg.sv
// Shared types for the HI/LO multiply/divide unit: operation and FSM enums plus
// the SPECIAL-opcode funct codes the decoder maps onto muldiv_op_t.
package muldiv_pkg;

  typedef enum logic [2:0] {
    MULT  = 3'd0,
    MULTU = 3'd1,
    DIV   = 3'd2,
    DIVU  = 3'd3,
    MTHI  = 3'd4,
    MTLO  = 3'd5
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } muldiv_state_t;

  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  // Only meaningful when is_muldiv_funct() is true for the same code.
  function automatic muldiv_op_t funct_to_op(input logic [5:0] funct);
    case (funct)
      FUNCT_MULT:  return MULT;
      FUNCT_MULTU: return MULTU;
      FUNCT_DIV:   return DIV;
      FUNCT_DIVU:  return DIVU;
      FUNCT_MTHI:  return MTHI;
      default:     return MTLO;
    endcase
  endfunction

  function automatic logic is_muldiv_funct(input logic [5:0] funct);
    return funct inside {FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU,
                         FUNCT_MTHI, FUNCT_MTLO};
  endfunction

endpackage

// File: rtl/muldiv_abs.sv
// Two's-complement magnitude with sign output; the invert input forces a
// negation so the same block also performs the result sign fix-up.
module muldiv_abs #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             is_signed,
  input  logic             invert,
  output logic [WIDTH-1:0] magnitude,
  output logic             sign
);

  assign sign      = is_signed & value[WIDTH-1];
  assign magnitude = (sign ^ invert) ? (~value + 1'b1) : value;

endmodule

// File: rtl/muldiv_hilo_unit.sv
// Iterative MIPS multiply/divide unit owning HI/LO (shift-add mul, restoring div).
// Define MULDIV_FAST_MULT_EN to compute MULT/MULTU with a single-cycle array product.
module muldiv_hilo_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_enable,
  input  logic             start,
  input  muldiv_op_t       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int            CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
`ifdef MULDIV_FAST_MULT_EN
  localparam logic FAST_MULT = 1'b1;
`else
  localparam logic FAST_MULT = 1'b0;
`endif

  muldiv_state_t    state, state_next;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] acc_hi, acc_lo, operand;
  logic             is_div, q_neg, r_neg;

  logic muldiv_op, div_op, signed_op, div_zero;
  assign muldiv_op = op inside {MULT, MULTU, DIV, DIVU};
  assign div_op    = (op == DIV) || (op == DIVU);
  assign signed_op = (op == MULT) || (op == DIV);
  assign div_zero  = (src_b == '0);
  assign busy      = (state != IDLE);

  // The operand abs blocks are idle outside accept, so FIX borrows them for negation.
  logic [WIDTH-1:0] a_value, b_value, mag_a, mag_b;
  logic             a_signed, b_signed, a_invert, b_invert, sign_a, sign_b;

  // NOTE: every always_comb output is defaulted first, so no path can infer a latch.
  always_comb begin
    a_value  = src_a;
    b_value  = src_b;
    // A zero divisor must return the dividend untouched, so skip its abs.
    a_signed = signed_op & ~(div_op & div_zero);
    b_signed = signed_op;
    a_invert = 1'b0;
    b_invert = 1'b0;
    if (state == FIX) begin
      a_value  = acc_lo;
      b_value  = acc_hi;
      a_signed = 1'b0;
      b_signed = 1'b0;
      a_invert = q_neg;
      b_invert = is_div ? r_neg : q_neg;
    end
  end

  muldiv_abs #(.WIDTH(WIDTH)) u_abs_a (
    .value(a_value), .is_signed(a_signed), .invert(a_invert),
    .magnitude(mag_a), .sign(sign_a)
  );

  muldiv_abs #(.WIDTH(WIDTH)) u_abs_b (
    .value(b_value), .is_signed(b_signed), .invert(b_invert),
    .magnitude(mag_b), .sign(sign_b)
  );

  // 2*WIDTH negation: the high half takes the carry only when the low half is zero.
  logic [WIDTH-1:0] fix_hi, fix_lo;
  assign fix_lo = mag_a;
  assign fix_hi = (is_div || !q_neg || acc_lo == '0) ? mag_b : ~acc_hi;

  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic             div_ok;
  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, operand};
  assign div_ok    = ~div_diff[WIDTH];

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start && muldiv_op) state_next = (FAST_MULT && !div_op) ? FIX : CALC;
      CALC:    if (count == LAST) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      count   <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      operand <= '0;
      is_div  <= 1'b0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else if (clk_enable) begin
      state <= state_next;
      done  <= (state == FIX);
      case (state)
        IDLE: begin
          if (start) begin
            if (op == MTHI) hi <= src_a;
            if (op == MTLO) lo <= src_a;
            if (muldiv_op) begin
              count   <= '0;
              is_div  <= div_op;
              q_neg   <= sign_a ^ sign_b;
              r_neg   <= sign_a;
              acc_hi  <= '0;
              acc_lo  <= div_op ? mag_a : mag_b;
              operand <= div_op ? mag_b : mag_a;
`ifdef MULDIV_FAST_MULT_EN
              if (!div_op) {acc_hi, acc_lo} <= (2*WIDTH)'(mag_a) * (2*WIDTH)'(mag_b);
`endif
            end
          end
        end
        CALC: begin
          count <= count + 1'b1;
          if (is_div) begin
            acc_hi <= div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], div_ok};
          end else begin
            {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
          end
        end
        FIX: begin
          hi <= fix_hi;
          lo <= fix_lo;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Directed bench for muldiv_hilo_unit: vector table for results and latency,
// plus sequences for MTHI/MTLO, ignored re-issue, stalls, back-to-back and reset.
module tb_muldiv_hilo_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk_enable = 1'b1;
  logic        start = 1'b0;
  muldiv_op_t  op_i = MULTU;
  logic [31:0] src_a = '0, src_b = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  muldiv_hilo_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .start(start), .op(op_i),
    .src_a(src_a), .src_b(src_b), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    muldiv_op_t  op;
    logic [31:0] a, b, exp_hi, exp_lo;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int exp_busy(input muldiv_op_t o);
`ifdef MULDIV_FAST_MULT_EN
    if (o == MULT || o == MULTU) return 1;
`endif
    return 33;
  endfunction

  // Called at a negedge: raises start for exactly one posedge.
  task automatic issue_now(input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b);
    op_i = o; src_a = a; src_b = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic issue(input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    issue_now(o, a, b);
  endtask

  // Counts busy negedges; optional stall window and mid-op re-issue of MULT 9*9.
  task automatic wait_done(input int exp, input string name,
                           input int freeze_at, input int freeze_len, input int poke_at);
    int n = 0;
    while (busy && n < 200) begin
      if (freeze_len > 0 && n == freeze_at) clk_enable = 1'b0;
      if (freeze_len > 0 && n == freeze_at + freeze_len) clk_enable = 1'b1;
      if (n == poke_at) begin
        op_i = MULT; src_a = 32'd9; src_b = 32'd9; start = 1'b1;
      end
      if (n == poke_at + 1) start = 1'b0;
      n++;
      @(negedge clk);
    end
    clk_enable = 1'b1;
    start = 1'b0;
    check({name, " busy_cycles"}, 64'(n), 64'(exp));
    check({name, " done"}, 64'(done), 64'd1);
  endtask

  initial begin
    vecs[0]  = '{MULT,  32'hFFFFFFFF, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFF9};
    vecs[1]  = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[2]  = '{DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{DIVU,  32'd7,        32'd0,        32'h00000007, 32'hFFFFFFFF};
    vecs[4]  = '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5]  = '{DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[6]  = '{DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF};
    vecs[7]  = '{MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[8]  = '{MULT,  32'd3,        32'hFFFFFFFB, 32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[9]  = '{DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E};
    vecs[10] = '{MULTU, 32'h12345678, 32'h10,       32'h00000001, 32'h23456780};
    vecs[11] = '{DIVU,  32'hFFFFFFFF, 32'h10,       32'h0000000F, 32'h0FFFFFFF};
    vecs[12] = '{MULT,  32'd0,        32'hFFFFFFFF, 32'h00000000, 32'h00000000};
    vecs[13] = '{DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003};

    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);

    issue(MTHI, 32'h1234, 32'h0);
    check("mthi hi", 64'(hi), 64'h1234);
    check("mthi done", 64'(done), 64'd0);
    check("mthi busy", 64'(busy), 64'd0);
    issue(MTLO, 32'h5678, 32'h0);
    check("mtlo lo", 64'(lo), 64'h5678);
    check("mtlo hi kept", 64'(hi), 64'h1234);

    for (int i = 0; i < 14; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(exp_busy(vecs[i].op), $sformatf("vec%0d", i), -1, 0, -1);
      check($sformatf("vec%0d hi", i), 64'(hi), 64'(vecs[i].exp_hi));
      check($sformatf("vec%0d lo", i), 64'(lo), 64'(vecs[i].exp_lo));
    end

    // Start re-pulsed while busy must not disturb the in-flight MULTU.
    issue(MULTU, 32'd3, 32'd5);
    wait_done(exp_busy(MULTU), "repulse", -1, 0, 5);
    check("repulse hi", 64'(hi), 64'd0);
    check("repulse lo", 64'(lo), 64'd15);
    @(negedge clk);
    check("repulse no second op", 64'(busy), 64'd0);
    check("done one pulse", 64'(done), 64'd0);

    // Stall four cycles mid-DIVU; then hold done high through a stall.
    issue(DIVU, 32'd1000, 32'd9);
    wait_done(37, "stall", 10, 4, -1);
    check("stall lo", 64'(lo), 64'd111);
    check("stall hi", 64'(hi), 64'd1);
    clk_enable = 1'b0;
    repeat (2) @(negedge clk);
    check("done held frozen", 64'(done), 64'd1);
    clk_enable = 1'b1;
    @(negedge clk);
    check("done drops", 64'(done), 64'd0);

    // Back-to-back: next op issued in the done cycle.
    issue(DIVU, 32'd50, 32'd6);
    wait_done(33, "b2b first", -1, 0, -1);
    issue_now(DIVU, 32'd100, 32'd7);
    wait_done(33, "b2b second", -1, 0, -1);
    check("b2b lo", 64'(lo), 64'd14);
    check("b2b hi", 64'(hi), 64'd2);

    // Asynchronous reset mid-op.
    issue(DIVU, 32'd77, 32'd3);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst mid busy", 64'(busy), 64'd0);
    check("rst mid done", 64'(done), 64'd0);
    check("rst mid hi", 64'(hi), 64'd0);
    check("rst mid lo", 64'(lo), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst stays idle", 64'(busy), 64'd0);
    check("rst no done", 64'(done), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
